// File: rtl/cpsr_stack.sv
// rtl/cpsr_stack.sv - condition flag register with masked update, branch evaluator and save/restore stack
// Optional feature: CPSR_FWD_EN (evaluator sees next-state flags instead of the current register)
module cpsr_stack #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NFLAGS-1:0] flag_in,
    input  logic [NFLAGS-1:0] flag_upd_mask,
    input  logic              cond_valid,
    input  logic [3:0]        cond_sel,
    input  logic              push,
    input  logic              pop,
    output logic [NFLAGS-1:0] flags_out,
    output logic              branch_taken,
    output logic              branch_vld,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] flags_q;
    logic [NFLAGS-1:0] flags_nxt;
    logic [NFLAGS-1:0] eval_flags;
    logic [NFLAGS-1:0] stack_mem [DEPTH];
    logic [CW-1:0]     count_q;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     wr_idx;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;
    logic              do_swap;
    logic              err_evt;
    logic              cond_res;
    logic              z_f, s_f, v_f, c_f;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = IW'(count_q - CW'(1));
    assign wr_idx  = IW'(count_q);

    // push&pop on an empty stack degrades to a plain push
    always_comb begin
        do_swap   = push & pop & ~empty;
        do_pop    = pop & ~push & ~empty;
        do_push   = push & (~pop | empty) & ~full;
        err_evt   = (push & ~pop & full) | (pop & ~push & empty);
        flags_nxt = (flags_q & ~flag_upd_mask) | (flag_in & flag_upd_mask);
        if (do_pop || do_swap) begin
            flags_nxt = stack_mem[top_idx];
        end else if (pop && !push) begin
            flags_nxt = flags_q;
        end
    end

`ifdef CPSR_FWD_EN
    assign eval_flags = flags_nxt;
`else
    assign eval_flags = flags_q;
`endif

    assign z_f = eval_flags[0];
    assign s_f = eval_flags[1];
    assign v_f = eval_flags[2];
    assign c_f = eval_flags[3];

    always_comb begin
        cond_res = 1'b0;
        case (cond_sel)
            4'd0:    cond_res = z_f;
            4'd1:    cond_res = ~z_f;
            4'd2:    cond_res = s_f ^ v_f;
            4'd3:    cond_res = ~(s_f ^ v_f);
            4'd4:    cond_res = v_f;
            4'd5:    cond_res = ~v_f;
            4'd6:    cond_res = s_f;
            4'd7:    cond_res = ~s_f;
            4'd8:    cond_res = c_f;
            4'd9:    cond_res = ~c_f;
            4'd10:   cond_res = ~z_f & ~(s_f ^ v_f);
            4'd11:   cond_res = z_f | (s_f ^ v_f);
            4'd12:   cond_res = 1'b1;
            default: cond_res = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q      <= '0;
            count_q      <= '0;
            stk_err      <= 1'b0;
            branch_vld   <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            flags_q    <= flags_nxt;
            branch_vld <= cond_valid;
            if (cond_valid) begin
                branch_taken <= cond_res;
            end
            if (err_evt) begin
                stk_err <= 1'b1;
            end
            if (do_push) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Stack contents are don't-care while count excludes them, so no reset here
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_push) begin
                stack_mem[wr_idx] <= flags_q;
            end else if (do_swap) begin
                stack_mem[top_idx] <= flags_q;
            end
        end
    end

    assign flags_out = flags_q;
    assign stk_full  = full;
    assign stk_empty = empty;

endmodule

// File: tb/tb_cpsr_stack.sv
// tb/tb_cpsr_stack.sv - self-checking bench for cpsr_stack against a queue-based behavioural model
module tb_cpsr_stack;

    localparam int NF = 4;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] flag_in;
    logic [NF-1:0] flag_upd_mask;
    logic          cond_valid;
    logic [3:0]    cond_sel;
    logic          push;
    logic          pop;
    logic [NF-1:0] flags_out;
    logic          branch_taken;
    logic          branch_vld;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_err;

    cpsr_stack #(.NFLAGS(NF), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .flag_in(flag_in), .flag_upd_mask(flag_upd_mask),
        .cond_valid(cond_valid), .cond_sel(cond_sel), .push(push), .pop(pop),
        .flags_out(flags_out), .branch_taken(branch_taken), .branch_vld(branch_vld),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_stk [$];
    logic          m_err;
    logic          m_vld;
    logic          m_taken;

    function automatic logic cond_of(input logic [3:0] sel, input logic [NF-1:0] f);
        logic z, s, v, c, lt;
        z = f[0]; s = f[1]; v = f[2]; c = f[3];
        lt = (s != v);
        if (sel == 0)       return z;
        else if (sel == 1)  return !z;
        else if (sel == 2)  return lt;
        else if (sel == 3)  return !lt;
        else if (sel == 4)  return v;
        else if (sel == 5)  return !v;
        else if (sel == 6)  return s;
        else if (sel == 7)  return !s;
        else if (sel == 8)  return c;
        else if (sel == 9)  return !c;
        else if (sel == 10) return !z && !lt;
        else if (sel == 11) return z || lt;
        else if (sel == 12) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("flags_out", 32'(flags_out), 32'(m_flags));
        cmp("stk_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
        cmp("stk_full", 32'(stk_full), 32'(m_stk.size() == DP));
        cmp("stk_err", 32'(stk_err), 32'(m_err));
        cmp("branch_vld", 32'(branch_vld), 32'(m_vld));
        if (m_vld) cmp("branch_taken", 32'(branch_taken), 32'(m_taken));
    endtask

    task automatic step(input logic rst, input logic [NF-1:0] fin, input logic [NF-1:0] msk,
                        input logic cv, input logic [3:0] cs, input logic pu, input logic po);
        logic [NF-1:0] nf;
        int sz;
        @(negedge clk);
        reset = rst; flag_in = fin; flag_upd_mask = msk;
        cond_valid = cv; cond_sel = cs; push = pu; pop = po;
        sz = m_stk.size();
        if (rst) begin
            m_flags = '0; m_stk.delete(); m_err = 0; m_vld = 0; m_taken = 0;
        end else begin
            nf = (m_flags & ~msk) | (fin & msk);
            if (po && pu && sz > 0) begin
                nf = m_stk[sz-1];
                m_stk[sz-1] = m_flags;
            end else if (po && !pu) begin
                if (sz > 0) nf = m_stk.pop_back();
                else begin nf = m_flags; m_err = 1; end
            end else if (pu) begin
                if (sz < DP) m_stk.push_back(m_flags);
                else m_err = 1;
            end
`ifdef CPSR_FWD_EN
            if (cv) m_taken = cond_of(cs, nf);
`else
            if (cv) m_taken = cond_of(cs, m_flags);
`endif
            m_vld = cv;
            m_flags = nf;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_flags(input logic [NF-1:0] v);
        step(0, v, '1, 0, 0, 0, 0);
    endtask

    task automatic eval(input logic [3:0] cs);
        step(0, '0, '0, 1, cs, 0, 0);
    endtask

    initial begin
        reset = 1; flag_in = '0; flag_upd_mask = '0; cond_valid = 0; cond_sel = '0; push = 0; pop = 0;
        m_flags = '0; m_err = 0; m_vld = 0; m_taken = 0;
        step(1, '0, '0, 0, 0, 0, 0);

        // T1: reset from a loaded state
        set_flags(4'hF);
        step(0, '0, '0, 0, 0, 1, 0);
        step(0, '0, '0, 1, 0, 1, 0);
        step(1, '0, '0, 0, 0, 0, 0);
        cmp("t1_flags", 32'(flags_out), 32'h0);
        cmp("t1_empty", 32'(stk_empty), 32'h1);
        cmp("t1_err", 32'(stk_err), 32'h0);
        cmp("t1_vld", 32'(branch_vld), 32'h0);

        // T2: masked update then EQ
        step(0, 4'b1111, 4'b0001, 0, 0, 0, 0);
        cmp("t2_flags", 32'(flags_out), 32'h1);
        eval(4'd0);
        cmp("t2_eq", 32'(branch_taken), 32'h1);
        cmp("t2_vld", 32'(branch_vld), 32'h1);
        step(0, '0, '0, 0, 0, 0, 0);
        cmp("t2_vld_drop", 32'(branch_vld), 32'h0);
        cmp("t2_hold", 32'(branch_taken), 32'h1);

        // T3: signed conditions
        set_flags(4'b0010);
        eval(4'd2);  cmp("t3_lt", 32'(branch_taken), 32'h1);
        eval(4'd3);  cmp("t3_ge", 32'(branch_taken), 32'h0);
        eval(4'd10); cmp("t3_gt", 32'(branch_taken), 32'h0);
        set_flags(4'b0110);
        eval(4'd3);  cmp("t3_ge_sv", 32'(branch_taken), 32'h1);
        eval(4'd12); cmp("t3_al", 32'(branch_taken), 32'h1);
        eval(4'd14); cmp("t3_nv", 32'(branch_taken), 32'h0);
        for (int k = 0; k < 16; k++) eval(4'(k));

        // T4: fill, overflow, drain
        step(1, '0, '0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            set_flags(4'(i));
            step(0, '0, '0, 0, 0, 1, 0);
        end
        cmp("t4_full", 32'(stk_full), 32'h1);
        step(0, '0, '0, 0, 0, 1, 0);
        cmp("t4_err", 32'(stk_err), 32'h1);
        cmp("t4_full2", 32'(stk_full), 32'h1);
        for (int i = 4; i >= 1; i--) begin
            step(0, '0, '0, 0, 0, 0, 1);
            cmp("t4_pop", 32'(flags_out), 32'(i));
        end
        cmp("t4_empty", 32'(stk_empty), 32'h1);

        // T5: swap, then pop to empty, then underflow
        step(1, '0, '0, 0, 0, 0, 0);
        set_flags(4'hA);
        step(0, '0, '0, 0, 0, 1, 0);
        set_flags(4'h3);
        step(0, '0, '0, 0, 0, 1, 1);
        cmp("t5_swap", 32'(flags_out), 32'hA);
        cmp("t5_err0", 32'(stk_err), 32'h0);
        step(0, '0, '0, 0, 0, 0, 1);
        cmp("t5_top", 32'(flags_out), 32'h3);
        step(0, 4'hF, 4'hF, 0, 0, 0, 1);
        cmp("t5_uflow_err", 32'(stk_err), 32'h1);
        cmp("t5_uflow_flags", 32'(flags_out), 32'h3);

        // T6: same-cycle update and evaluate
        step(1, '0, '0, 0, 0, 0, 0);
        step(0, 4'b0001, 4'b0001, 1, 4'd0, 0, 0);
`ifdef CPSR_FWD_EN
        cmp("t6_fwd", 32'(branch_taken), 32'h1);
`else
        cmp("t6_nofwd", 32'(branch_taken), 32'h0);
`endif

        // Simultaneous events: push+update, pop+update, eval+pop
        set_flags(4'h5);
        step(0, 4'hC, 4'hF, 0, 0, 1, 0);
        cmp("push_upd_reg", 32'(flags_out), 32'hC);
        step(0, 4'h2, 4'hF, 1, 4'd0, 0, 1);
        cmp("pop_upd_flags", 32'(flags_out), 32'h5);

        // Mixed sweep scored against the model every cycle
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 40) == 0, 4'($urandom), 4'($urandom),
                 1'($urandom), 4'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
